// File: rtl/vga_mon_pkg.sv
// Shared types and constants for the VGA frame monitor.
//   mon_state_e            : monitor FSM states
//   CRC_POLY / CRC_INIT    : CRC-16-CCITT parameters for the signature
//   DEF_H_ACTIVE/V_ACTIVE  : default visible geometry (640x480)
//   DEF_CW                 : default x/y counter width
package vga_mon_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_CW       = 11;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2,
    CHECK  = 2'd3
  } mon_state_e;

endpackage : vga_mon_pkg

// File: rtl/vga_mon_crc16.sv
// Combinational CRC-16-CCITT update over one 24-bit {R,G,B} pixel, MSB first.
//   crc_in    in  16  running CRC before this pixel
//   data      in  24  pixel colour {R,G,B}
//   crc_out_c out 16  CRC after shifting in all 24 bits
module vga_mon_crc16
  import vga_mon_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [23:0] data,
  output logic [15:0] crc_out_c
);

  logic [15:0] crc;

  // Bit-serial LFSR unrolled over the 24 data bits, bit 23 first.
  always_comb begin
    crc = crc_in;
    for (int i = 23; i >= 0; i--) begin
      if (crc[15] ^ data[i]) begin
        crc = {crc[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc = {crc[14:0], 1'b0};
      end
    end
    crc_out_c = crc;
  end

endmodule : vga_mon_crc16

// File: rtl/vga_frame_monitor.sv
// VGA receive-side frame monitor: samples the VGA bus on pix_en, rebuilds
// pixel coordinates, checks frame geometry and produces a per-frame signature.
// Build option: define VGA_MON_CRC_EN for a CRC-16-CCITT signature over
// {R,G,B}; otherwise the signature is the 16-bit sum of R+G+B.
// Ports:
//   clk, reset (async, active low), pix_en (one strobe per pixel)
//   vga_hs, vga_vs (active-low syncs), vga_blank_n, vga_r/g/b
//   pix_x, pix_y, pix_valid : coordinates of the last sampled active pixel
//   frame_done              : one-clk pulse per checked frame
//   frame_ok, frame_sig     : result of last checked frame (held)
//   frame_cnt               : frames checked since reset (wraps)
module vga_frame_monitor
  import vga_mon_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  input  logic          vga_hs,
  input  logic          vga_vs,
  input  logic          vga_blank_n,
  input  logic [7:0]    vga_r,
  input  logic [7:0]    vga_g,
  input  logic [7:0]    vga_b,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_valid,
  output logic          frame_done,
  output logic          frame_ok,
  output logic [15:0]   frame_sig,
  output logic [15:0]   frame_cnt
);

  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] LINE_LEN  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] LAST_LINE = CW'(V_ACTIVE - 1);
`ifdef VGA_MON_CRC_EN
  localparam logic [15:0] SIG_INIT = CRC_INIT;
`else
  localparam logic [15:0] SIG_INIT = 16'h0000;
`endif

  mon_state_e    state;
  logic          hs_q;
  logic          vs_q;
  logic          blank_q;
  logic          err;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic [15:0]   acc;

  logic          hs_fall_c;
  logic          vs_fall_c;
  logic [CW-1:0] x_inc_c;
  logic [CW-1:0] y_inc_c;
  logic [15:0]   acc_next_c;

  assign hs_fall_c = hs_q & ~vga_hs;
  assign vs_fall_c = vs_q & ~vga_vs;

  // Saturating increments; hitting the ceiling is flagged as a geometry error.
  assign x_inc_c = (x == CNT_MAX) ? x : x + CW'(1);
  assign y_inc_c = (y == CNT_MAX) ? y : y + CW'(1);

  // Signature update for the pixel on the bus.
`ifdef VGA_MON_CRC_EN
  vga_mon_crc16 u_crc (
    .crc_in    (acc),
    .data      ({vga_r, vga_g, vga_b}),
    .crc_out_c (acc_next_c)
  );
`else
  assign acc_next_c = acc + 16'(vga_r) + 16'(vga_g) + 16'(vga_b);
`endif

  // Sync edge history, frame FSM, counters and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_q    <= 1'b0;
      err        <= 1'b0;
      x          <= '0;
      y          <= '0;
      acc        <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_sig  <= '0;
      frame_cnt  <= '0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_en) begin
        hs_q    <= vga_hs;
        vs_q    <= vga_vs;
        blank_q <= vga_blank_n;
        unique case (state)
          // First VS fall only arms; the partial frame is never reported.
          IDLE: begin
            if (vs_fall_c) begin
              state <= SYNC;
              err   <= 1'b0;
              x     <= '0;
              y     <= '0;
              acc   <= SIG_INIT;
            end
          end
          SYNC: begin
            if (vs_fall_c) begin
              err   <= 1'b1;  // frame with no active pixels
              state <= CHECK;
            end else if (vga_blank_n) begin
              state     <= ACTIVE;
              x         <= CW'(1);
              y         <= '0;
              acc       <= acc_next_c;
              pix_x     <= '0;
              pix_y     <= '0;
              pix_valid <= 1'b1;
            end
          end
          ACTIVE: begin
            if (vs_fall_c) begin
              // VS overrides HS; an open line is length-checked first.
              if (blank_q && (x != LINE_LEN)) err <= 1'b1;
              state <= CHECK;
            end else if (vga_blank_n) begin
              pix_valid <= 1'b1;
              acc       <= acc_next_c;
              if (!blank_q) begin
                pix_x <= '0;
                pix_y <= y_inc_c;
                y     <= y_inc_c;
                x     <= CW'(1);
                if (y == CNT_MAX) err <= 1'b1;
              end else begin
                pix_x <= x;
                pix_y <= y;
                x     <= x_inc_c;
                if (x == CNT_MAX) err <= 1'b1;
              end
              // Horizontal sync during active video is a geometry error.
              if (hs_fall_c) err <= 1'b1;
            end else if (blank_q) begin
              if (x != LINE_LEN) err <= 1'b1;
            end
          end
          CHECK: begin
            frame_ok   <= !err && (y == LAST_LINE);
            frame_sig  <= acc;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            err        <= 1'b0;
            x          <= '0;
            y          <= '0;
            acc        <= SIG_INIT;
            state      <= SYNC;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule : vga_frame_monitor

// File: tb/tb_vga_frame_monitor.sv
// Scoreboard bench for vga_frame_monitor on a reduced 16x8 geometry.
// Stimulus tasks push expected coordinates and frame results into queues;
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_vga_frame_monitor;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int CW = 8;
  localparam int HB = 8;
  localparam int VB = 4;
  localparam int LT = H + HB;

`ifdef VGA_MON_CRC_EN
  localparam logic [15:0] M_INIT = 16'hFFFF;
`else
  localparam logic [15:0] M_INIT = 16'h0000;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_en;
  logic          vga_hs;
  logic          vga_vs;
  logic          vga_blank_n;
  logic [7:0]    vga_r;
  logic [7:0]    vga_g;
  logic [7:0]    vga_b;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic          pix_valid;
  logic          frame_done;
  logic          frame_ok;
  logic [15:0]   frame_sig;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  vga_frame_monitor #(.H_ACTIVE(H), .V_ACTIVE(V), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_valid   (pix_valid),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok),
    .frame_sig   (frame_sig),
    .frame_cnt   (frame_cnt)
  );

  int          n_tests = 0;
  int          n_fail  = 0;

  // Scoreboard queues
  int          exp_x_q[$];
  int          exp_y_q[$];
  logic        exp_ok_q[$];
  logic [15:0] exp_sig_q[$];
  logic [15:0] exp_cnt_q[$];

  // Reference model state for the frame being driven
  bit          armed = 0;
  bit          m_bad = 0;
  int          m_lines = 0;
  logic [15:0] m_sig = M_INIT;
  logic [15:0] m_cnt = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signature of one pixel: byte-wise CRC-CCITT or plain modular sum.
  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [7:0] r,
                                           input logic [7:0] g, input logic [7:0] b);
    logic [15:0] c;
    logic [7:0]  bytes [3];
`ifdef VGA_MON_CRC_EN
    bytes[0] = r;
    bytes[1] = g;
    bytes[2] = b;
    c = s;
    for (int k = 0; k < 3; k++) begin
      c = c ^ {bytes[k], 8'h00};
      for (int n = 0; n < 8; n++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
`else
    bytes[0] = 8'h00;
    bytes[1] = 8'h00;
    bytes[2] = 8'h00;
    c = s + {8'h00, r} + {8'h00, g} + {8'h00, b} + {8'h00, bytes[0]};
`endif
    return c;
  endfunction

  task automatic step(input logic hs, input logic vs, input logic blank,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(negedge clk);
    vga_hs      = hs;
    vga_vs      = vs;
    vga_blank_n = blank;
    vga_r       = r;
    vga_g       = g;
    vga_b       = b;
    pix_en      = 1'b1;
    @(negedge clk);
    pix_en      = 1'b0;
  endtask

  // A VS fall closes the current frame in the model and (re)arms it.
  task automatic vs_event();
    if (armed) begin
      m_cnt = m_cnt + 16'd1;
      exp_ok_q.push_back(!m_bad && (m_lines == V));
      exp_sig_q.push_back(m_sig);
      exp_cnt_q.push_back(m_cnt);
    end
    armed   = 1;
    m_bad   = 0;
    m_lines = 0;
    m_sig   = M_INIT;
  endtask

  // cmode: 0 random colour, 1 solid 8'h01, 2 black.
  task automatic drive_line(input int len, input int cmode, input bit cut);
    logic [7:0] r, g, b;
    for (int i = 0; i < len; i++) begin
      case (cmode)
        1:       begin r = 8'h01; g = 8'h01; b = 8'h01; end
        2:       begin r = 8'h00; g = 8'h00; b = 8'h00; end
        default: begin r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); end
      endcase
      if (armed) begin
        exp_x_q.push_back(i);
        exp_y_q.push_back(m_lines);
        m_sig = sig_step(m_sig, r, g, b);
      end
      step(1'b1, 1'b1, 1'b1, r, g, b);
    end
    m_lines++;
    if (len != H) m_bad = 1;
    if (!cut) begin
      for (int j = 0; j < HB; j++) step(!(j >= 2 && j < 5), 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    end
  endtask

  task automatic drive_vblank(input int vs_start);
    int   j;
    logic vs_low;
    for (int s = 0; s < VB * LT; s++) begin
      j      = s % LT;
      vs_low = (s >= vs_start) && (s < vs_start + LT);
      if (s == vs_start) vs_event();
      step(!(j >= 2 && j < 5), !vs_low, 1'b0, 8'h00, 8'h00, 8'h00);
    end
  endtask

  task automatic drive_frame(input int nl, input int bad_line, input int bad_len,
                             input bit cut, input int cmode, input bit same_edge);
    for (int l = 0; l < nl; l++) begin
      drive_line((l == bad_line) ? bad_len : H, cmode, cut && (l == nl - 1));
    end
    if (cut && nl > 0)  drive_vblank(0);
    else if (same_edge) drive_vblank(LT + 2);
    else                drive_vblank(LT + 10);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pix_x"},      32'(pix_x),      32'd0);
    check({tag, "_pix_y"},      32'(pix_y),      32'd0);
    check({tag, "_pix_valid"},  32'(pix_valid),  32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_frame_ok"},   32'(frame_ok),   32'd0);
    check({tag, "_frame_sig"},  32'(frame_sig),  32'd0);
    check({tag, "_frame_cnt"},  32'(frame_cnt),  32'd0);
  endtask

  // Monitor: every DUT output event is matched against the scoreboard.
  always @(negedge clk) begin
    if (pix_valid) begin
      if (exp_x_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pix_valid: got unexpected pixel (%0d,%0d) expected none at %0t",
                 pix_x, pix_y, $time);
      end else begin
        check("pix_x", 32'(pix_x), 32'(exp_x_q.pop_front()));
        check("pix_y", 32'(pix_y), 32'(exp_y_q.pop_front()));
      end
    end
    if (frame_done) begin
      if (exp_ok_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL frame_done: got unexpected pulse (cnt %0d) expected none at %0t",
                 frame_cnt, $time);
      end else begin
        check("frame_ok",  32'(frame_ok),  32'(exp_ok_q.pop_front()));
        check("frame_sig", 32'(frame_sig), 32'(exp_sig_q.pop_front()));
        check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt_q.pop_front()));
      end
    end
  end

  initial begin
    reset       = 1'b0;
    pix_en      = 1'b0;
    vga_hs      = 1'b1;
    vga_vs      = 1'b1;
    vga_blank_n = 1'b0;
    vga_r       = 8'h00;
    vga_g       = 8'h00;
    vga_b       = 8'h00;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Warm-up frame: its VS only arms the monitor
    drive_frame(V, -1, 0, 0, 2, 0);
    // Nominal frames
    drive_frame(V, -1, 0, 0, 2, 0);
    drive_frame(V, -1, 0, 0, 0, 0);
    // Solid colour signature
    drive_frame(V, -1, 0, 0, 1, 0);
    // Short line, then a clean frame
    drive_frame(V, 3, H - 1, 0, 0, 0);
    drive_frame(V, -1, 0, 0, 0, 0);
    // Over-length line
    drive_frame(V, 5, H + 3, 0, 0, 0);
    // Short frame
    drive_frame(V - 1, -1, 0, 0, 0, 0);
    // HS and VS fall on the same sample
    drive_frame(V, -1, 0, 0, 0, 1);
    // VS falls right as the last line ends: short and exact length
    drive_frame(V, V - 1, H - 2, 1, 0, 0);
    drive_frame(V, -1, 0, 1, 0, 0);
    // Frame with no active pixels
    drive_frame(0, -1, 0, 0, 0, 0);

    // Reset in the middle of a frame
    for (int l = 0; l < V / 2; l++) drive_line(H, 0, 0);
    @(negedge clk);
    check("queues_before_reset", 32'(exp_x_q.size() + exp_ok_q.size()), 32'd0);
    reset = 1'b0;
    #1;
    check_outputs_zero("midreset");
    armed   = 0;
    m_cnt   = 16'd0;
    m_bad   = 0;
    m_lines = 0;
    exp_x_q.delete();
    exp_y_q.delete();
    exp_ok_q.delete();
    exp_sig_q.delete();
    exp_cnt_q.delete();
    @(negedge clk);
    reset = 1'b1;
    // Rest of the interrupted frame: its VS only re-arms
    drive_frame(V - V / 2, -1, 0, 0, 0, 0);
    drive_frame(V, -1, 0, 0, 0, 0);

    // Randomised frames
    for (int k = 0; k < 8; k++) begin
      int nl, bl, blen;
      bit cut, se;
      nl   = V - 1 + int'($urandom_range(0, 2));
      bl   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
      blen = ($urandom_range(0, 1) == 1) ? H - 1 - int'($urandom_range(0, 3))
                                         : H + 1 + int'($urandom_range(0, 3));
      cut  = ($urandom_range(0, 3) == 0);
      se   = ($urandom_range(0, 1) == 1);
      drive_frame(nl, bl, blen, cut, 0, se);
    end

    repeat (10) @(negedge clk);
    check("pixels_outstanding", 32'(exp_x_q.size()), 32'd0);
    check("frames_outstanding", 32'(exp_ok_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_vga_frame_monitor
